// File: rtl/pc_fetch_unit_pkg.sv
// Purpose : shared types and constants for the instruction fetch stage.
// Latency : n/a (types, constants and a helper only).
// Backpr. : n/a.
package pc_fetch_unit_pkg;

    // Fetch sequencer states. BOOT is a single dead cycle after reset,
    // HALT is terminal until the next reset.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    // Canonical RISC-V NOP (addi x0, x0, 0), for downstream bubble filling.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequential PC increment; wraps modulo 2^32 with no flag.
    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Purpose : instruction-memory fetch bus between the fetch unit and imem.
// Latency : imem_rdata/imem_ready answer imem_addr in the same cycle.
// Backpr. : imem_ready=0 means no word this cycle; the requester retries.
// Ports   : imem_addr/imem_req (fetch -> mem), imem_rdata/imem_ready (mem -> fetch).
interface pc_fetch_unit_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/pc_fetch_unit_if_id_register.sv
// Purpose : IF/ID pipeline register with load / valid-clear / hold controls.
// Latency : one edge from load to outputs.
// Backpr. : neither load nor clear asserted -> everything holds.
// Ports   : clk, rst_n; load (capture all fields, valid=1), clear (valid=0 only);
//           pc_in/pc_plus4_in/instr_in -> if_id_pc/if_id_pc_plus4/if_id_instr/if_id_valid.
module if_id_register (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc_plus4_in,
    input  logic [31:0] instr_in,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    // Clear only drops valid: bubbles and redirects keep the payload fields.
    always_comb begin
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        if (load) begin
            pc_d       = pc_in;
            pc_plus4_d = pc_plus4_in;
            instr_d    = instr_in;
            valid_d    = 1'b1;
        end else if (clear) begin
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            pc_plus4_q <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    assign if_id_pc       = pc_q;
    assign if_id_pc_plus4 = pc_plus4_q;
    assign if_id_instr    = instr_q;
    assign if_id_valid    = valid_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// Purpose : PC register, fetch sequencer and redirect handling feeding IF/ID.
// Latency : fetched word appears on if_id_* one edge after the imem_ready cycle.
// Backpr. : stall holds PC and IF/ID (no request); imem_ready=0 inserts a bubble.
// Ports   : clk, rst_n; stall, branch_taken, jump, jalr, branch_target, jalr_target;
//           imem (fetch bus, master side); if_id_* outputs, flush, misaligned.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic                   jump,
    input  logic                   jalr,
    input  logic [31:0]            branch_target,
    input  logic [31:0]            jalr_target,
    pc_fetch_unit_if.master        imem,
    output logic [31:0]            if_id_pc,
    output logic [31:0]            if_id_pc_plus4,
    output logic [31:0]            if_id_instr,
    output logic                   if_id_valid,
    output logic                   flush,
    output logic                   misaligned
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         misaligned_q, misaligned_d;
    logic         redirect;
    logic [31:0]  target;
    logic         ifid_load;
    logic         ifid_clear;

    assign redirect = branch_taken | jump | jalr;
    // jump and branch share the PC-relative target; jalr wins and drops bit 0.
    assign target   = jalr ? {jalr_target[31:1], 1'b0} : branch_target;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        misaligned_d  = misaligned_q;
        ifid_load     = 1'b0;
        ifid_clear    = 1'b0;
        flush         = 1'b0;
        imem.imem_req = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem.imem_req = ~stall;
                // A redirect beats both stall and a returning fetch word.
                if (redirect) begin
                    ifid_clear = 1'b1;
                    if (target[1]) begin
                        // Not word aligned: freeze here rather than fetch garbage.
                        misaligned_d = 1'b1;
                        state_d      = ST_HALT;
                    end else begin
                        pc_d  = target;
                        flush = 1'b1;
                    end
                end else if (!stall) begin
                    if (imem.imem_ready) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_incr(pc_q);
                    end else begin
                        ifid_clear = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign misaligned     = misaligned_q;

    if_id_register u_if_id (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (ifid_load),
        .clear          (ifid_clear),
        .pc_in          (pc_q),
        .pc_plus4_in    (pc_incr(pc_q)),
        .instr_in       (imem.imem_rdata),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid)
    );
endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst2_n;
    logic        stall, bt, jump, jalr, ready;
    logic [31:0] btgt, jtgt;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    pc_fetch_unit_if imem0();
    pc_fetch_unit_if imem1();
    assign imem0.imem_ready = ready;
    assign imem1.imem_ready = ready;
    assign imem0.imem_rdata = instr_of(imem0.imem_addr);
    assign imem1.imem_rdata = instr_of(imem1.imem_addr);

    logic [31:0] ifpc0, ifpc4_0, ifins0, ifpc1, ifpc4_1, ifins1;
    logic        ifv0, fl0, mis0, ifv1, fl1, mis1;

    pc_fetch_unit u_dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(bt), .jump(jump),
        .jalr(jalr), .branch_target(btgt), .jalr_target(jtgt), .imem(imem0),
        .if_id_pc(ifpc0), .if_id_pc_plus4(ifpc4_0), .if_id_instr(ifins0),
        .if_id_valid(ifv0), .flush(fl0), .misaligned(mis0)
    );

    pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_dut1 (
        .clk(clk), .rst_n(rst2_n), .stall(stall), .branch_taken(bt), .jump(jump),
        .jalr(jalr), .branch_target(btgt), .jalr_target(jtgt), .imem(imem1),
        .if_id_pc(ifpc1), .if_id_pc_plus4(ifpc4_1), .if_id_instr(ifins1),
        .if_id_valid(ifv1), .flush(fl1), .misaligned(mis1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall, bt, jump, jalr, ready;
        logic [31:0] btgt, jtgt;
        logic        exp_flush, exp_req;
        logic [31:0] exp_pc, exp_ifpc;
        logic        exp_valid;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    initial begin
        //          stall bt jmp jalr rdy  btgt          jtgt          flush req  pc            ifpc          valid
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,        32'h0,        1'b0,1'b1, 32'h4,        32'h0,        1'b1};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,        32'h0,        1'b0,1'b1, 32'h8,        32'h4,        1'b1};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 32'h0,        32'h0,        1'b0,1'b0, 32'h8,        32'h4,        1'b1};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        1'b0,1'b1, 32'h8,        32'h4,        1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,        32'h0,        1'b0,1'b1, 32'hC,        32'h8,        1'b1};
        vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, 32'h10,       32'h0,        1'b1,1'b0, 32'h10,       32'h8,        1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, 32'h40,       32'h0,        1'b1,1'b0, 32'h40,       32'h8,        1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,        32'h0,        1'b0,1'b1, 32'h44,       32'h40,       1'b1};
        vecs[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b1, 32'h200,      32'h81,       1'b1,1'b1, 32'h80,       32'h40,       1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h20,       32'h0,        1'b1,1'b1, 32'h20,       32'h40,       1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        1'b0,1'b1, 32'h20,       32'h40,       1'b0};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        1'b0,1'b1, 32'h20,       32'h40,       1'b0};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,        1'b0,1'b1, 32'h20,       32'h40,       1'b0};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,        32'h0,        1'b0,1'b1, 32'h24,       32'h20,       1'b1};
        vecs[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h1000,     32'h0,        1'b1,1'b1, 32'h1000,     32'h20,       1'b0};

        rst_n = 1'b0; rst2_n = 1'b0;
        stall = 1'b0; bt = 1'b0; jump = 1'b0; jalr = 1'b0; ready = 1'b1;
        btgt = '0; jtgt = '0;

        // Reset state.
        #12;
        chk("rst_addr",  imem0.imem_addr, 32'h0);
        chk("rst_req",   imem0.imem_req,  32'h0);
        chk("rst_flush", fl0,   32'h0);
        chk("rst_valid", ifv0,  32'h0);
        chk("rst_mis",   mis0,  32'h0);
        chk("rst_ifpc",  ifpc0, 32'h0);
        chk("rst_ifins", ifins0, 32'h0);

        // Release: one BOOT cycle without a request.
        @(negedge clk); rst_n = 1'b1;
        #1 chk("boot_req", imem0.imem_req, 32'h0);
        @(posedge clk); #1;
        chk("boot_addr",  imem0.imem_addr, 32'h0);
        chk("boot_valid", ifv0, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            stall = vecs[i].stall; bt = vecs[i].bt; jump = vecs[i].jump;
            jalr = vecs[i].jalr; ready = vecs[i].ready;
            btgt = vecs[i].btgt; jtgt = vecs[i].jtgt;
            #1;
            chk($sformatf("v%0d_flush", i), fl0, vecs[i].exp_flush);
            chk($sformatf("v%0d_req", i), imem0.imem_req, vecs[i].exp_req);
            @(posedge clk); #1;
            chk($sformatf("v%0d_pc", i), imem0.imem_addr, vecs[i].exp_pc);
            chk($sformatf("v%0d_ifpc", i), ifpc0, vecs[i].exp_ifpc);
            chk($sformatf("v%0d_ifpc4", i), ifpc4_0, vecs[i].exp_ifpc + 32'd4);
            chk($sformatf("v%0d_ifins", i), ifins0, instr_of(vecs[i].exp_ifpc));
            chk($sformatf("v%0d_valid", i), ifv0, vecs[i].exp_valid);
            chk($sformatf("v%0d_mis", i), mis0, 32'h0);
        end

        // Misaligned jump target: sticky flag, PC frozen, HALT ignores everything.
        @(negedge clk);
        stall = 1'b0; bt = 1'b0; jump = 1'b1; jalr = 1'b0; ready = 1'b1; btgt = 32'h102;
        #1 chk("mis_pre", mis0, 32'h0);
        @(posedge clk); #1;
        chk("mis_set",   mis0, 32'h1);
        chk("mis_pc",    imem0.imem_addr, 32'h1000);
        chk("mis_valid", ifv0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            jump = 1'b0; bt = 1'b1; btgt = 32'h200;
            #1;
            chk($sformatf("halt%0d_req", k), imem0.imem_req, 32'h0);
            chk($sformatf("halt%0d_flush", k), fl0, 32'h0);
            @(posedge clk); #1;
            chk($sformatf("halt%0d_pc", k), imem0.imem_addr, 32'h1000);
            chk($sformatf("halt%0d_mis", k), mis0, 32'h1);
        end

        // Asynchronous reset out of HALT, mid-cycle.
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("hrst_addr", imem0.imem_addr, 32'h0);
        chk("hrst_mis",  mis0, 32'h0);
        chk("hrst_req",  imem0.imem_req, 32'h0);
        chk("hrst_ifpc", ifpc0, 32'h0);
        chk("hrst_ifins", ifins0, 32'h0);
        bt = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1 chk("hrst_boot_req", imem0.imem_req, 32'h0);
        @(posedge clk);
        @(negedge clk); #1;
        chk("hrst_fetch_req", imem0.imem_req, 32'h1);

        // Reset vector at the top of memory: PC+4 wraps to zero.
        chk("wrap_rst_addr", imem1.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        stall = 1'b0; ready = 1'b1; rst2_n = 1'b1;
        #1 chk("wrap_boot_req", imem1.imem_req, 32'h0);
        @(posedge clk);
        @(negedge clk); #1;
        chk("wrap_req",  imem1.imem_req, 32'h1);
        chk("wrap_addr", imem1.imem_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        chk("wrap_pc",    imem1.imem_addr, 32'h0);
        chk("wrap_ifpc",  ifpc1, 32'hFFFF_FFFC);
        chk("wrap_ifpc4", ifpc4_1, 32'h0);
        chk("wrap_ifins", ifins1, instr_of(32'hFFFF_FFFC));
        chk("wrap_valid", ifv1, 32'h1);
        @(negedge clk); stall = 1'b1;
        #1 chk("wrap_stall_req", imem1.imem_req, 32'h0);
        @(posedge clk); #1;
        chk("wrap_stall_pc", imem1.imem_addr, 32'h0);
        @(negedge clk); #2 rst2_n = 1'b0;
        #1;
        chk("wrst_addr",  imem1.imem_addr, 32'hFFFF_FFFC);
        chk("wrst_ifpc",  ifpc1, 32'h0);
        chk("wrst_ifpc4", ifpc4_1, 32'h0);
        chk("wrst_ifins", ifins1, 32'h0);
        chk("wrst_valid", ifv1, 32'h0);
        chk("wrst_req",   imem1.imem_req, 32'h0);
        chk("wrst_flush", fl1, 32'h0);
        chk("wrst_mis",   mis1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
